command_capture: RTL and testbench
==================================

COMMAND_CAPTURE -- requirements
Module: command_capture

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 50000, the number of consecutive equal samples that qualifies an enter level (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-004 The block SHALL have port enter_sync, input, 1 bit, the already-synchronized enter button level (1 = pressed).
REQ-005 The block SHALL have port acoes_sync, input, 6 bits, the already-synchronized action switches.
REQ-006 The block SHALL have port cmd_ready, input, 1 bit, asserted by the consumer to accept the current command.
REQ-007 The block SHALL have port cmd_valid, output, 1 bit, which is high while a captured command is offered.
REQ-008 The block SHALL have port cmd_acoes, output, 6 bits, carrying the captured action code.
REQ-009 The block SHALL have port busy, output, 1 bit, which is high in every state except IDLE.

Function
REQ-010 The block SHALL implement four states: IDLE, PRESS_DEB, OFFER and REL_DEB, together with a debounce counter wide enough to hold DEB_CYCLES.
REQ-011 In IDLE, on an edge with enter_sync=1, the block SHALL move to PRESS_DEB with count=1; otherwise it SHALL remain in IDLE.
REQ-012 In PRESS_DEB, on an edge with enter_sync=0, the block SHALL return to IDLE with count=0 (bounce rejected).
REQ-013 In PRESS_DEB, on an edge with enter_sync=1 and count=DEB_CYCLES-1, the block SHALL register acoes_sync into cmd_acoes, go to OFFER and set count=0; otherwise it SHALL increment count.
REQ-014 The latency SHALL be as follows: when enter_sync is 1 at DEB_CYCLES consecutive edges E1..EN, cmd_valid SHALL be 1 immediately after EN, and cmd_acoes SHALL equal acoes_sync as sampled at EN.
REQ-015 cmd_valid SHALL be 1 exactly when the state is OFFER.
REQ-016 cmd_acoes SHALL change only on a capture edge and SHALL hold its value in all other states.
REQ-017 In OFFER, on an edge with cmd_ready=1, the block SHALL go to REL_DEB with count=0, so that cmd_valid is low after that edge; a transfer is one such edge.
REQ-018 In OFFER with cmd_ready=0, the block SHALL stay in OFFER indefinitely, ignoring enter_sync and acoes_sync.
REQ-019 cmd_ready SHALL be ignored in every state other than OFFER.
REQ-020 In REL_DEB, on an edge with enter_sync=1, the block SHALL set count=0.
REQ-021 In REL_DEB, on an edge with enter_sync=0, the block SHALL increment count, and when count=DEB_CYCLES-1 on such an edge it SHALL go to IDLE with count=0.
REQ-022 A button held continuously after a transfer SHALL never produce a second command; exactly one command SHALL be issued per debounced press.
REQ-023 The counter SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-024 busy SHALL be registered state decoding, with no combinational path from any input to any output.

Reset
REQ-025 On an edge with reset=1, the block SHALL set the state to REL_DEB, count=0, cmd_valid=0 and cmd_acoes=6'b000000; busy SHALL be 1 after that edge.
REQ-026 Reset SHALL take priority over all transitions, including a simultaneous cmd_ready=1 or a capture edge.
REQ-027 Because reset enters REL_DEB, a button held through reset SHALL NOT generate a command; DEB_CYCLES consecutive low samples are required before the first press is accepted.

Verification (DEB_CYCLES=4)
REQ-028 Scenario: reset 1 cycle, then enter_sync=0 for 4 edges -> busy=0; then enter_sync=1 for 4 edges with acoes_sync=6'h2A -> cmd_valid=1 and cmd_acoes=6'h2A after the 4th edge, and not before.
REQ-029 Scenario: enter_sync sequence 1,1,1,0,1,1,1,1 starting from IDLE -> cmd_valid rises only after the 8th edge, and cmd_acoes equals acoes_sync at that edge.
REQ-030 Scenario: in OFFER, hold cmd_ready=0 for 10 edges while acoes_sync changes to 6'h15 -> cmd_valid stays 1 and cmd_acoes stays 6'h2A; then cmd_ready=1 for 1 edge -> cmd_valid=0.
REQ-031 Scenario: after a transfer, keep enter_sync=1 for 20 edges -> no cmd_valid; then enter_sync=0 for 4 edges and 1 for 4 edges -> exactly one new command.
REQ-032 Scenario: assert reset while cmd_valid=1 with enter_sync held high -> cmd_valid=0 and cmd_acoes=0 after that edge, with no command until 4 lows and then 4 highs.
REQ-033 Scenario: pulse cmd_ready=1 in IDLE and in PRESS_DEB -> no state change and no spurious cmd_valid.

Source files
------------

// File: rtl/command_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : command_capture                                         |
// | Description : Debounces the enter button, captures the 6-bit action   |
// |               switches on a qualified press and offers them through a |
// |               valid/ready handshake. One command per debounced press. |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module command_capture #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_sync,
  input  logic [5:0] acoes_sync,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [5:0] cmd_acoes,
  output logic       busy
);

  // Counter only ever holds 0..DEB_CYCLES-1, so clog2 bits are enough.
  localparam int            CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] C_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    OFFER     = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    acoes_q, acoes_d;

  // State, debounce counter and captured code; reset lands in release
  // debounce so a button held through reset cannot issue a command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REL_DEB;
      count_q <= C_ZERO;
      acoes_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acoes_q <= acoes_d;
    end
  end

  // Next-state logic: press debounce, offer hold, release debounce.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acoes_d = acoes_q;
    case (state_q)
      IDLE: begin
        if (enter_sync) begin
          state_d = PRESS_DEB;
          count_d = C_ONE;
        end
      end
      PRESS_DEB: begin
        if (!enter_sync) begin
          // Bounce: the press was not held long enough.
          state_d = IDLE;
          count_d = C_ZERO;
        end else if (count_q == C_LAST) begin
          state_d = OFFER;
          count_d = C_ZERO;
          acoes_d = acoes_sync;
        end else begin
          count_d = count_q + C_ONE;
        end
      end
      OFFER: begin
        // Inputs other than cmd_ready are deliberately ignored here.
        if (cmd_ready) begin
          state_d = REL_DEB;
          count_d = C_ZERO;
        end
      end
      REL_DEB: begin
        if (enter_sync) begin
          // Still pressed (or bouncing): restart the release window.
          count_d = C_ZERO;
        end else if (count_q == C_LAST) begin
          state_d = IDLE;
          count_d = C_ZERO;
        end else begin
          count_d = count_q + C_ONE;
        end
      end
      default: begin
        state_d = REL_DEB;
        count_d = C_ZERO;
      end
    endcase
  end

  // Outputs are pure decodes of registered state; no input reaches them.
  assign cmd_valid = (state_q == OFFER);
  assign busy      = (state_q != IDLE);
  assign cmd_acoes = acoes_q;

endmodule
`default_nettype wire

// File: tb/tb_command_capture.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_command_capture                                      |
// | Description : Randomized and directed bench for command_capture with  |
// |               a behavioural press/release model and a command queue.  |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module tb_command_capture;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       enter_sync;
  logic [5:0] acoes_sync;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [5:0] cmd_acoes;
  logic       busy;

  int n_cmp;
  int n_bad;

  command_capture #(.DEB_CYCLES(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .enter_sync (enter_sync),
    .acoes_sync (acoes_sync),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_acoes  (cmd_acoes),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "armed" means N consecutive lows have been seen
  // since the last transfer/reset; a command fires on the N-th
  // consecutive high while armed.
  bit         m_started;
  bit         m_armed;
  bit         m_offer;
  int         m_lows;
  int         m_highs;
  logic [5:0] m_acoes;
  logic [5:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic e, input logic [5:0] a,
                            input logic r, input logic rs);
    if (rs) begin
      m_started = 1'b1;
      m_armed   = 1'b0;
      m_offer   = 1'b0;
      m_lows    = 0;
      m_highs   = 0;
      m_acoes   = 6'h00;
    end else if (!m_started) begin
      // Nothing defined before the first reset.
    end else if (m_offer) begin
      if (r) begin
        m_offer = 1'b0;
        m_armed = 1'b0;
        m_lows  = 0;
      end
    end else if (!m_armed) begin
      m_lows = e ? 0 : m_lows + 1;
      if (m_lows == N) begin
        m_armed = 1'b1;
        m_highs = 0;
      end
    end else begin
      m_highs = e ? m_highs + 1 : 0;
      if (m_highs == N) begin
        m_offer = 1'b1;
        m_acoes = a;
        m_highs = 0;
        exp_q.push_back(a);
      end
    end
  endtask

  // One clock edge of stimulus; the model is advanced with the same values.
  task automatic step(input logic e, input logic [5:0] a,
                      input logic r, input logic rs);
    enter_sync = e;
    acoes_sync = a;
    cmd_ready  = r;
    reset      = rs;
    @(posedge clk);
    model_edge(e, a, r, rs);
    #3;
  endtask

  task automatic steps(input int n, input logic e, input logic [5:0] a,
                       input logic r);
    for (int i = 0; i < n; i++) step(e, a, r, 1'b0);
  endtask

  // Monitor: compares every cycle against the model and pops the queue
  // whenever the DUT starts offering a new command.
  logic prev_valid;
  initial prev_valid = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (m_started) begin
      chk("cmd_valid", int'(cmd_valid), int'(m_offer));
      chk("busy", int'(busy), int'(m_offer || !m_armed || m_highs != 0));
      chk("cmd_acoes", int'(cmd_acoes), int'(m_acoes));
      if (cmd_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got cmd %0h expected none", cmd_acoes);
        end else begin
          chk("sb_cmd", int'(cmd_acoes), int'(exp_q.pop_front()));
        end
      end
      prev_valid = cmd_valid;
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_started = 1'b0;
    m_armed = 1'b0;
    m_offer = 1'b0;
    m_lows = 0;
    m_highs = 0;
    m_acoes = 6'h00;
    enter_sync = 1'b0;
    acoes_sync = 6'h00;
    cmd_ready  = 1'b0;
    reset      = 1'b0;
    #2;

    // Reset state, then release and press debounce.
    step(1'b0, 6'h00, 1'b0, 1'b1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_acoes", int'(cmd_acoes), 0);
    steps(N, 1'b0, 6'h00, 1'b0);
    chk("idle_busy", int'(busy), 0);
    steps(N - 1, 1'b1, 6'h2A, 1'b0);
    chk("press_early", int'(cmd_valid), 0);
    step(1'b1, 6'h2A, 1'b0, 1'b0);
    chk("press_valid", int'(cmd_valid), 1);
    chk("press_acoes", int'(cmd_acoes), 6'h2A);

    // Offer held against changing switches, then transfer.
    steps(10, 1'b1, 6'h15, 1'b0);
    chk("hold_valid", int'(cmd_valid), 1);
    chk("hold_acoes", int'(cmd_acoes), 6'h2A);
    step(1'b1, 6'h15, 1'b1, 1'b0);
    chk("xfer_valid", int'(cmd_valid), 0);

    // Held button after transfer never re-fires.
    steps(20, 1'b1, 6'h07, 1'b0);
    chk("held_valid", int'(cmd_valid), 0);
    steps(N, 1'b0, 6'h07, 1'b0);
    steps(N, 1'b1, 6'h33, 1'b0);
    chk("second_cmd", int'(cmd_acoes), 6'h33);
    step(1'b1, 6'h33, 1'b1, 1'b0);
    steps(N, 1'b0, 6'h00, 1'b0);

    // Bounce sequence 1,1,1,0,1,1,1,1 from IDLE.
    step(1'b1, 6'h01, 1'b0, 1'b0);
    step(1'b1, 6'h02, 1'b0, 1'b0);
    step(1'b1, 6'h03, 1'b0, 1'b0);
    step(1'b0, 6'h04, 1'b0, 1'b0);
    step(1'b1, 6'h05, 1'b0, 1'b0);
    step(1'b1, 6'h06, 1'b0, 1'b0);
    step(1'b1, 6'h07, 1'b0, 1'b0);
    chk("bounce_early", int'(cmd_valid), 0);
    step(1'b1, 6'h3C, 1'b0, 1'b0);
    chk("bounce_valid", int'(cmd_valid), 1);
    chk("bounce_acoes", int'(cmd_acoes), 6'h3C);

    // Reset while offering with the button held and ready high.
    step(1'b1, 6'h3C, 1'b1, 1'b1);
    chk("rst_offer_valid", int'(cmd_valid), 0);
    chk("rst_offer_acoes", int'(cmd_acoes), 0);
    steps(6, 1'b1, 6'h11, 1'b0);
    chk("rst_held_valid", int'(cmd_valid), 0);
    steps(N, 1'b0, 6'h11, 1'b0);
    steps(N, 1'b1, 6'h22, 1'b0);
    chk("rst_after_cmd", int'(cmd_acoes), 6'h22);
    step(1'b0, 6'h22, 1'b1, 1'b0);
    steps(N, 1'b0, 6'h00, 1'b0);

    // cmd_ready pulses in IDLE and PRESS_DEB have no effect.
    step(1'b0, 6'h00, 1'b1, 1'b0);
    chk("rdy_idle_busy", int'(busy), 0);
    step(1'b1, 6'h09, 1'b1, 1'b0);
    step(1'b1, 6'h09, 1'b1, 1'b0);
    chk("rdy_press_valid", int'(cmd_valid), 0);
    steps(N - 2, 1'b1, 6'h09, 1'b0);
    chk("rdy_press_cmd", int'(cmd_valid), 1);
    step(1'b1, 6'h09, 1'b1, 1'b0);

    // Randomized runs of button levels, ready and occasional reset.
    for (int s = 0; s < 300; s++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        logic lv;
        lv = ($urandom_range(0, 19) == 0) ? ~lvl : lvl;
        step(lv, 6'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 200) == 0));
      end
    end

    step(1'b0, 6'h00, 1'b0, 1'b0);
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
